// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU control decoder and its multiply/divide unit.
package alu_ctrl_pkg;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [1:0] CLS_ADD   = 2'b00;
  localparam logic [1:0] CLS_SUB   = 2'b01;
  localparam logic [1:0] CLS_RTYPE = 2'b10;
  localparam logic [1:0] CLS_ITYPE = 2'b11;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SLL     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SRA     = 4'b0101;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_XOR     = 4'b1101;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_HI  = 2'b01;
  localparam logic [1:0] RES_LO  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  // Matches funct[1:0] of MULT/MULTU/DIV/DIVU.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step per cycle,
// sign fix-up applied combinationally on the final accumulator.
module mdu_iter
  import alu_ctrl_pkg::*;
#(
  parameter int NBITS = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  mdu_op_e          op_i,
  input  logic [NBITS-1:0] rs_i,
  input  logic [NBITS-1:0] rt_i,
  input  logic             step_i,
  output logic             last_o,
  output logic [NBITS-1:0] hi_o,
  output logic [NBITS-1:0] lo_o
);
  localparam int CW = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  logic [2*NBITS-1:0] acc_q, acc_d;
  logic [NBITS-1:0]   a_q, a_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, dz_q, dz_d;

  logic               signed_s, is_div_s, rs_neg_s, rt_neg_s, dz_s;
  logic [NBITS-1:0]   rs_mag_s, rt_mag_s;
  logic [NBITS:0]     sum_s, rem_sh_s, diff_s;
  logic [2*NBITS-1:0] prod_s;

  assign signed_s = (op_i == MDU_MULT) || (op_i == MDU_DIV);
  assign is_div_s = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
  assign rs_neg_s = signed_s && rs_i[NBITS-1];
  assign rt_neg_s = signed_s && rt_i[NBITS-1];
  assign rs_mag_s = rs_neg_s ? -rs_i : rs_i;
  assign rt_mag_s = rt_neg_s ? -rt_i : rt_i;
  assign dz_s     = is_div_s && (rt_i == {NBITS{1'b0}});

  // acc holds {partial product, multiplier} for mult and {remainder, quotient} for div.
  assign sum_s    = {1'b0, acc_q[2*NBITS-1:NBITS]} + (acc_q[0] ? {1'b0, a_q} : {(NBITS+1){1'b0}});
  assign rem_sh_s = {acc_q[2*NBITS-1:NBITS], acc_q[NBITS-1]};
  assign diff_s   = rem_sh_s - {1'b0, a_q};

  // Next-state of the iterative datapath.
  always_comb begin
    acc_d     = acc_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    if (start_i) begin
      a_d       = rt_mag_s;
      acc_d     = {{NBITS{1'b0}}, (dz_s ? rs_i : rs_mag_s)};
      cnt_d     = {CW{1'b0}};
      div_d     = is_div_s;
      neg_d     = rs_neg_s ^ rt_neg_s;
      neg_rem_d = rs_neg_s;
      dz_d      = dz_s;
    end else if (step_i) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        if (!diff_s[NBITS]) begin
          acc_d = {diff_s[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh_s[NBITS-1:0], acc_q[NBITS-2:0], 1'b0};
        end
      end else begin
        acc_d = {sum_s, acc_q[NBITS-1:1]};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q     <= {(2*NBITS){1'b0}};
      a_q       <= {NBITS{1'b0}};
      cnt_q     <= {CW{1'b0}};
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  assign last_o = (cnt_q == LAST);
  assign prod_s = neg_q ? -acc_q : acc_q;

  // Sign-corrected results, valid while the top-level FSM sits in FIX.
  always_comb begin
    if (dz_q) begin
      hi_o = acc_q[NBITS-1:0];
      lo_o = {NBITS{1'b1}};
    end else if (div_q) begin
      lo_o = neg_q ? -acc_q[NBITS-1:0] : acc_q[NBITS-1:0];
      hi_o = neg_rem_q ? -acc_q[2*NBITS-1:NBITS] : acc_q[2*NBITS-1:NBITS];
    end else begin
      hi_o = prod_s[2*NBITS-1:NBITS];
      lo_o = prod_s[NBITS-1:0];
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// EX-stage ALU control decoder with HI/LO registers and the multiply/divide sequencer.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int NBITS        = 32,
  parameter int ANBITS       = 6,
  parameter int NBITSCONTROL = 2,
  parameter int ALUOP        = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [NBITSCONTROL-1:0] i_ALUOp,
  input  logic [ANBITS-1:0]       i_Funct,
  input  logic [ANBITS-1:0]       i_Opcode,
  input  logic [NBITS-1:0]        i_rs_data,
  input  logic [NBITS-1:0]        i_rt_data,
  output logic [ALUOP-1:0]        o_ALUOp,
  output logic                    o_Shamt,
  output logic                    o_illegal,
  output logic [1:0]              o_res_sel,
  output logic                    o_busy,
  output logic [NBITS-1:0]        o_hi,
  output logic [NBITS-1:0]        o_lo
);
  mdu_state_e       state_q;
  logic [NBITS-1:0] hi_q, lo_q;
  logic             mthi_s, mtlo_s, muldiv_s, accept_s, mdu_last_s;
  logic [NBITS-1:0] mdu_hi_s, mdu_lo_s;

  // Instruction decode.
  always_comb begin
    o_ALUOp   = ALU_ILLEGAL;
    o_illegal = 1'b1;
    o_Shamt   = 1'b0;
    o_res_sel = RES_ALU;
    mthi_s    = 1'b0;
    mtlo_s    = 1'b0;
    muldiv_s  = 1'b0;
    case (i_ALUOp)
      CLS_ADD: begin o_ALUOp = ALU_ADD; o_illegal = 1'b0; end
      CLS_SUB: begin o_ALUOp = ALU_SUB; o_illegal = 1'b0; end
      CLS_RTYPE: begin
        o_illegal = 1'b0;
        case (i_Funct)
          F_ADD, F_ADDU:  o_ALUOp = ALU_ADD;
          F_SUB, F_SUBU:  o_ALUOp = ALU_SUB;
          F_AND:          o_ALUOp = ALU_AND;
          F_OR:           o_ALUOp = ALU_OR;
          F_NOR:          o_ALUOp = ALU_NOR;
          F_XOR:          o_ALUOp = ALU_XOR;
          F_SLT:          o_ALUOp = ALU_SLT;
          F_SLL:          begin o_ALUOp = ALU_SLL; o_Shamt = 1'b1; end
          F_SRL:          begin o_ALUOp = ALU_SRL; o_Shamt = 1'b1; end
          F_SRA:          begin o_ALUOp = ALU_SRA; o_Shamt = 1'b1; end
          F_SLLV:         o_ALUOp = ALU_SLL;
          F_SRLV:         o_ALUOp = ALU_SRL;
          F_SRAV:         o_ALUOp = ALU_SRA;
          F_MFHI:         begin o_ALUOp = ALU_ADD; o_res_sel = RES_HI; end
          F_MFLO:         begin o_ALUOp = ALU_ADD; o_res_sel = RES_LO; end
          F_MTHI:         begin o_ALUOp = ALU_ADD; mthi_s = 1'b1; end
          F_MTLO:         begin o_ALUOp = ALU_ADD; mtlo_s = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin o_ALUOp = ALU_ADD; muldiv_s = 1'b1; end
          default:        begin o_ALUOp = ALU_ILLEGAL; o_illegal = 1'b1; end
        endcase
      end
      CLS_ITYPE: begin
        o_illegal = 1'b0;
        case (i_Opcode)
          OP_SLTI:            o_ALUOp = ALU_SLT;
          OP_ANDI:            o_ALUOp = ALU_AND;
          OP_ORI:             o_ALUOp = ALU_OR;
          OP_XORI:            o_ALUOp = ALU_XOR;
          OP_ADDI, OP_ADDIU:  o_ALUOp = ALU_ADD;
          default:            begin o_ALUOp = ALU_ILLEGAL; o_illegal = 1'b1; end
        endcase
      end
      default: begin o_ALUOp = ALU_ILLEGAL; o_illegal = 1'b1; end
    endcase
  end

  assign accept_s = i_valid && (state_q == ST_IDLE) && (i_ALUOp == CLS_RTYPE);

  mdu_iter #(.NBITS(NBITS)) u_mdu (
    .clk_i   (i_clk),
    .reset_i (i_reset),
    .start_i (accept_s && muldiv_s),
    .op_i    (mdu_op_e'(i_Funct[1:0])),
    .rs_i    (i_rs_data),
    .rt_i    (i_rt_data),
    .step_i  (state_q == ST_RUN),
    .last_o  (mdu_last_s),
    .hi_o    (mdu_hi_s),
    .lo_o    (mdu_lo_s)
  );

  // Sequencer FSM and HI/LO registers; divide by zero skips RUN entirely.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      hi_q    <= {NBITS{1'b0}};
      lo_q    <= {NBITS{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s && mthi_s) begin
            hi_q <= i_rs_data;
          end else if (accept_s && mtlo_s) begin
            lo_q <= i_rs_data;
          end else if (accept_s && muldiv_s) begin
            state_q <= (i_Funct[1] && (i_rt_data == {NBITS{1'b0}})) ? ST_FIX : ST_RUN;
          end
        end
        ST_RUN: begin
          if (mdu_last_s) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= mdu_hi_s;
          lo_q    <= mdu_lo_s;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (state_q != ST_IDLE);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule
